// File: rtl/mult_execution_unit.sv
// rtl/mult_execution_unit.sv - pipelined shift-add integer multiplier (MUL/MULH/MULHSU/MULHU) for an OoO core
// Stage 0 registers the extended operands; stages 1..STAGES each fold in XLEN/STAGES multiplier bits.
module mult_execution_unit #(
    parameter int XLEN   = 32,
    parameter int STAGES = 4,
    parameter int TAG_W  = 5
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [XLEN-1:0]  opa,
    input  logic [XLEN-1:0]  opb,
    input  logic [1:0]       func,
    input  logic [TAG_W-1:0] rob_tag,
    input  logic             squash,
    output logic             out_valid,
    output logic [XLEN-1:0]  out_value,
    output logic [TAG_W-1:0] out_rob_tag,
    input  logic             cdb_grant,
    output logic             busy
);

    localparam int CHUNK = XLEN / STAGES;
    localparam int PW    = 2 * XLEN;

    logic [STAGES:0] valid_q, valid_d;
    logic [TAG_W-1:0] tag_q    [STAGES+1];
    logic [TAG_W-1:0] tag_d    [STAGES+1];
    logic [1:0]       func_q   [STAGES+1];
    logic [1:0]       func_d   [STAGES+1];
    logic [PW-1:0]    mcand_q  [STAGES+1];
    logic [PW-1:0]    mcand_d  [STAGES+1];
    logic [XLEN-1:0]  mplier_q [STAGES+1];
    logic [XLEN-1:0]  mplier_d [STAGES+1];
    logic [PW-1:0]    psum_q   [STAGES+1];
    logic [PW-1:0]    psum_d   [STAGES+1];
    logic             stall;

    // A signed multiplier is handled by giving its top bit negative weight,
    // so only XLEN multiplier bits ever need to be consumed.
    function automatic logic [PW-1:0] shift_add(
        input logic [PW-1:0]    psum,
        input logic [PW-1:0]    mcand,
        input logic [CHUNK-1:0] bits,
        input logic             neg_top
    );
        logic [PW-1:0] acc;
        acc = psum;
        for (int j = 0; j < CHUNK; j++) begin
            if (bits[j]) begin
                if (neg_top && (j == CHUNK - 1)) acc = acc - (mcand << j);
                else                             acc = acc + (mcand << j);
            end
        end
        return acc;
    endfunction

    always_comb begin
        stall    = valid_q[STAGES] & ~cdb_grant;
        in_ready = ~squash & ~stall;
        valid_d  = valid_q;
        tag_d    = tag_q;
        func_d   = func_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        psum_d   = psum_q;
        if (squash) begin
            valid_d = '0;
        end else if (!stall) begin
            valid_d[0]  = in_valid;
            tag_d[0]    = rob_tag;
            func_d[0]   = func;
            mcand_d[0]  = (func != 2'b11) ? {{XLEN{opa[XLEN-1]}}, opa} : {{XLEN{1'b0}}, opa};
            mplier_d[0] = opb;
            psum_d[0]   = '0;
            for (int k = 0; k < STAGES; k++) begin
                valid_d[k+1]  = valid_q[k];
                tag_d[k+1]    = tag_q[k];
                func_d[k+1]   = func_q[k];
                psum_d[k+1]   = shift_add(psum_q[k], mcand_q[k], mplier_q[k][CHUNK-1:0],
                                          (k == STAGES - 1) && !func_q[k][1]);
                mcand_d[k+1]  = mcand_q[k] << CHUNK;
                mplier_d[k+1] = mplier_q[k] >> CHUNK;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            valid_q <= '0;
            for (int k = 0; k <= STAGES; k++) begin
                tag_q[k]    <= '0;
                func_q[k]   <= '0;
                mcand_q[k]  <= '0;
                mplier_q[k] <= '0;
                psum_q[k]   <= '0;
            end
        end else begin
            valid_q  <= valid_d;
            tag_q    <= tag_d;
            func_q   <= func_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            psum_q   <= psum_d;
        end
    end

    assign out_valid   = valid_q[STAGES];
    assign out_value   = !out_valid ? '0 :
                         (func_q[STAGES] == 2'b00) ? psum_q[STAGES][XLEN-1:0] : psum_q[STAGES][PW-1:XLEN];
    assign out_rob_tag = out_valid ? tag_q[STAGES] : '0;
    assign busy        = |valid_q;

endmodule

// File: tb/tb_mult_execution_unit.sv
// tb/tb_mult_execution_unit.sv - randomized and directed bench for mult_execution_unit at STAGES 4, 1 and 8
module tb_mult_execution_unit;

    typedef struct {
        logic [1:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  t;
    } op_t;

    logic        clock = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [31:0] opa;
    logic [31:0] opb;
    logic [1:0]  func;
    logic [4:0]  rob_tag;
    logic        squash;
    logic        cdb_grant;
    logic        rdy  [3];
    logic        ov   [3];
    logic [31:0] oval [3];
    logic [4:0]  otag [3];
    logic        bsy  [3];

    int errors = 0;
    int checks = 0;
    int stage_of [3] = '{4, 1, 8};

    always #5 clock = ~clock;

    mult_execution_unit #(.XLEN(32), .STAGES(4), .TAG_W(5)) u_dut4 (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(rdy[0]),
        .opa(opa), .opb(opb), .func(func), .rob_tag(rob_tag), .squash(squash),
        .out_valid(ov[0]), .out_value(oval[0]), .out_rob_tag(otag[0]),
        .cdb_grant(cdb_grant), .busy(bsy[0]));

    mult_execution_unit #(.XLEN(32), .STAGES(1), .TAG_W(5)) u_dut1 (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(rdy[1]),
        .opa(opa), .opb(opb), .func(func), .rob_tag(rob_tag), .squash(squash),
        .out_valid(ov[1]), .out_value(oval[1]), .out_rob_tag(otag[1]),
        .cdb_grant(cdb_grant), .busy(bsy[1]));

    mult_execution_unit #(.XLEN(32), .STAGES(8), .TAG_W(5)) u_dut8 (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(rdy[2]),
        .opa(opa), .opb(opb), .func(func), .rob_tag(rob_tag), .squash(squash),
        .out_valid(ov[2]), .out_value(oval[2]), .out_rob_tag(otag[2]),
        .cdb_grant(cdb_grant), .busy(bsy[2]));

    // Reference: extend both operands to 64 bits and take one full-width product.
    function automatic logic [31:0] ref_result(input logic [1:0] f, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] ea, eb, p;
        ea = (f != 2'b11) ? {{32{a[31]}}, a} : {32'b0, a};
        eb = (f[1] == 1'b0) ? {{32{b[31]}}, b} : {32'b0, b};
        p  = ea * eb;
        return (f == 2'b00) ? p[31:0] : p[63:32];
    endfunction

    function automatic logic [31:0] rand_operand();
        case ($urandom_range(0, 7))
            0:       return 32'h8000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h7FFF_FFFF;
            3:       return $urandom_range(0, 15);
            default: return $urandom;
        endcase
    endfunction

    function automatic op_t rand_op(input logic [4:0] t);
        op_t o;
        o.f = 2'($urandom_range(0, 3));
        o.a = rand_operand();
        o.b = rand_operand();
        o.t = t;
        return o;
    endfunction

    task automatic drive_op(input op_t o);
        func    = o.f;
        opa     = o.a;
        opb     = o.b;
        rob_tag = o.t;
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        in_valid  = 1'b0;
        squash    = 1'b0;
        cdb_grant = 1'b1;
        opa = '0; opb = '0; func = '0; rob_tag = '0;
        @(posedge clock);
        #3 reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; in_valid = 1'b0; squash = 1'b0; cdb_grant = 1'b0;
        opa = '0; opb = '0; func = '0; rob_tag = '0;
        #12;
        for (int i = 0; i < 3; i++) begin
            checks += 5;
            if (ov[i] !== 1'b0)    begin errors++; $display("FAIL reset_out_valid[%0d] got=%b exp=0", i, ov[i]); end
            if (oval[i] !== 32'h0) begin errors++; $display("FAIL reset_out_value[%0d] got=%h exp=0", i, oval[i]); end
            if (otag[i] !== 5'h0)  begin errors++; $display("FAIL reset_out_tag[%0d] got=%h exp=0", i, otag[i]); end
            if (bsy[i] !== 1'b0)   begin errors++; $display("FAIL reset_busy[%0d] got=%b exp=0", i, bsy[i]); end
            if (rdy[i] !== 1'b1)   begin errors++; $display("FAIL reset_in_ready[%0d] got=%b exp=1", i, rdy[i]); end
        end
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic test_latency_values();
        op_t         v  [5];
        logic [31:0] ev [5];
        v[0] = '{2'b00, 32'd7,         32'd6,         5'd3}; ev[0] = 32'd42;
        v[1] = '{2'b01, 32'h8000_0000, 32'h8000_0000, 5'd1}; ev[1] = 32'h4000_0000;
        v[2] = '{2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2}; ev[2] = 32'hFFFF_FFFE;
        v[3] = '{2'b10, 32'hFFFF_FFFF, 32'd2,         5'd4}; ev[3] = 32'hFFFF_FFFF;
        v[4] = '{2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd5}; ev[4] = 32'h0000_0001;
        for (int k = 0; k < 5; k++) begin
            int          lat [3];
            int          cnt [3];
            logic [31:0] val [3];
            logic [4:0]  tg  [3];
            @(negedge clock);
            drive_op(v[k]);
            in_valid  = 1'b1;
            cdb_grant = 1'b1;
            @(posedge clock);
            #1 in_valid = 1'b0;
            for (int i = 0; i < 3; i++) begin lat[i] = 0; cnt[i] = 0; val[i] = 'x; tg[i] = 'x; end
            for (int n = 1; n <= 12; n++) begin
                @(posedge clock);
                #1;
                for (int i = 0; i < 3; i++) begin
                    if (ov[i]) begin
                        cnt[i]++;
                        if (lat[i] == 0) begin lat[i] = n; val[i] = oval[i]; tg[i] = otag[i]; end
                    end
                end
            end
            for (int i = 0; i < 3; i++) begin
                checks += 4;
                if (lat[i] != stage_of[i]) begin errors++; $display("FAIL latency[v%0d,S=%0d] got=%0d exp=%0d", k, stage_of[i], lat[i], stage_of[i]); end
                if (cnt[i] != 1)           begin errors++; $display("FAIL pulse_count[v%0d,S=%0d] got=%0d exp=1", k, stage_of[i], cnt[i]); end
                if (val[i] !== ev[k])      begin errors++; $display("FAIL value[v%0d,S=%0d] got=%h exp=%h", k, stage_of[i], val[i], ev[k]); end
                if (tg[i] !== v[k].t)      begin errors++; $display("FAIL tag[v%0d,S=%0d] got=%h exp=%h", k, stage_of[i], tg[i], v[k].t); end
            end
        end
    endtask

    task automatic test_back_to_back_stall();
        op_t         ops [5];
        int          issued = 0;
        int          got = 0;
        int          stall_left = -1;
        logic [31:0] stall_val = '0;
        logic        accepted;
        do_reset();
        for (int k = 0; k < 5; k++) ops[k] = rand_op(5'(10 + k));
        for (int cyc = 0; cyc < 40; cyc++) begin
            @(negedge clock);
            in_valid = (issued < 5);
            if (issued < 5) drive_op(ops[issued]);
            if (stall_left < 0 && ov[0]) begin stall_left = 3; stall_val = oval[0]; end
            cdb_grant = !(stall_left > 0);
            #1;
            if (stall_left > 0) begin
                checks += 2;
                if (rdy[0] !== 1'b0)      begin errors++; $display("FAIL b2b_in_ready_stall got=%b exp=0", rdy[0]); end
                if (oval[0] !== stall_val) begin errors++; $display("FAIL b2b_value_stable got=%h exp=%h", oval[0], stall_val); end
            end
            if (ov[0] && cdb_grant) begin
                checks++;
                if (got >= 5) begin
                    errors++; $display("FAIL b2b_extra_result got=%h exp=none", oval[0]);
                end else if (oval[0] !== ref_result(ops[got].f, ops[got].a, ops[got].b) || otag[0] !== ops[got].t) begin
                    errors++;
                    $display("FAIL b2b_result[%0d] got=%h/%h exp=%h/%h", got, oval[0], otag[0],
                             ref_result(ops[got].f, ops[got].a, ops[got].b), ops[got].t);
                end
                got++;
            end
            accepted = in_valid && rdy[0];
            @(posedge clock);
            if (accepted) issued++;
            if (stall_left > 0) stall_left--;
        end
        in_valid = 1'b0;
        checks += 2;
        if (got != 5)    begin errors++; $display("FAIL b2b_result_count got=%0d exp=5", got); end
        if (issued != 5) begin errors++; $display("FAIL b2b_issue_count got=%0d exp=5", issued); end
    endtask

    task automatic test_squash();
        int seen = 0;
        do_reset();
        for (int c = 1; c <= 5; c++) begin
            @(negedge clock);
            drive_op(rand_op(5'(20 + c)));
            in_valid = (c <= 3) || (c == 5);
            squash   = (c == 5);
            #1;
            if (ov[0]) seen++;
            if (c == 5) begin
                checks++;
                if (rdy[0] !== 1'b0) begin errors++; $display("FAIL squash_in_ready got=%b exp=0", rdy[0]); end
            end
        end
        @(posedge clock);
        #1 squash = 1'b0; in_valid = 1'b0;
        checks++;
        if (bsy[0] !== 1'b0) begin errors++; $display("FAIL squash_busy got=%b exp=0", bsy[0]); end
        for (int n = 0; n < 12; n++) begin
            @(negedge clock);
            if (ov[0]) seen++;
        end
        checks++;
        if (seen != 0) begin errors++; $display("FAIL squash_out_valid_cycles got=%0d exp=0", seen); end
    endtask

    task automatic test_async_reset();
        int   seen = 0;
        int   lat = 0;
        logic [31:0] val = 'x;
        do_reset();
        for (int c = 0; c < 4; c++) begin
            @(negedge clock);
            drive_op(rand_op(5'(c)));
            in_valid = 1'b1;
        end
        @(posedge clock);
        #1 in_valid = 1'b0;
        #2;
        checks++;
        if (bsy[0] !== 1'b1) begin errors++; $display("FAIL areset_busy_before got=%b exp=1", bsy[0]); end
        reset = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) begin
            checks += 2;
            if (ov[i] !== 1'b0)  begin errors++; $display("FAIL areset_out_valid[%0d] got=%b exp=0", i, ov[i]); end
            if (bsy[i] !== 1'b0) begin errors++; $display("FAIL areset_busy[%0d] got=%b exp=0", i, bsy[i]); end
        end
        @(posedge clock);
        #3 reset = 1'b0;
        for (int n = 0; n < 12; n++) begin
            @(negedge clock);
            for (int i = 0; i < 3; i++) if (ov[i] || bsy[i]) seen++;
        end
        checks++;
        if (seen != 0) begin errors++; $display("FAIL areset_activity_after_release got=%0d exp=0", seen); end
        // first edge after a release must accept an issue
        reset = 1'b1;
        @(posedge clock);
        #3 reset = 1'b0;
        drive_op('{2'b00, 32'd7, 32'd6, 5'd3});
        in_valid = 1'b1;
        #1;
        checks++;
        if (rdy[0] !== 1'b1) begin errors++; $display("FAIL first_issue_in_ready got=%b exp=1", rdy[0]); end
        @(posedge clock);
        #1 in_valid = 1'b0;
        for (int n = 1; n <= 10; n++) begin
            @(posedge clock);
            #1;
            if (ov[0] && lat == 0) begin lat = n; val = oval[0]; end
        end
        checks += 2;
        if (lat != 4)      begin errors++; $display("FAIL first_issue_latency got=%0d exp=4", lat); end
        if (val !== 32'd42) begin errors++; $display("FAIL first_issue_value got=%h exp=%h", val, 32'd42); end
    endtask

    task automatic test_random_stream();
        logic [31:0] exp_val [$];
        logic [4:0]  exp_tag [$];
        logic        prev_stall = 1'b0;
        logic [31:0] prev_val = '0;
        logic [4:0]  prev_tag = '0;
        logic        accepted;
        op_t         o;
        do_reset();
        for (int cyc = 0; cyc < 620; cyc++) begin
            @(negedge clock);
            o = rand_op(5'($urandom_range(0, 31)));
            drive_op(o);
            in_valid  = (cyc < 600) && ($urandom_range(0, 9) < 7);
            cdb_grant = (cyc >= 600) || ($urandom_range(0, 3) != 0);
            #1;
            checks++;
            if (rdy[0] !== !(ov[0] && !cdb_grant)) begin
                errors++; $display("FAIL rand_in_ready got=%b exp=%b", rdy[0], !(ov[0] && !cdb_grant));
            end
            if (prev_stall) begin
                checks++;
                if (ov[0] !== 1'b1 || oval[0] !== prev_val || otag[0] !== prev_tag) begin
                    errors++; $display("FAIL rand_stall_hold got=%b/%h/%h exp=1/%h/%h", ov[0], oval[0], otag[0], prev_val, prev_tag);
                end
            end
            if (ov[0] && cdb_grant) begin
                checks++;
                if (exp_val.size() == 0) begin
                    errors++; $display("FAIL rand_unexpected_result got=%h exp=none", oval[0]);
                end else begin
                    if (oval[0] !== exp_val[0] || otag[0] !== exp_tag[0]) begin
                        errors++; $display("FAIL rand_result got=%h/%h exp=%h/%h", oval[0], otag[0], exp_val[0], exp_tag[0]);
                    end
                    void'(exp_val.pop_front());
                    void'(exp_tag.pop_front());
                end
            end
            prev_stall = ov[0] && !cdb_grant;
            prev_val   = oval[0];
            prev_tag   = otag[0];
            accepted   = in_valid && rdy[0];
            if (accepted) begin
                exp_val.push_back(ref_result(o.f, o.a, o.b));
                exp_tag.push_back(o.t);
            end
            @(posedge clock);
        end
        in_valid = 1'b0;
        #1;
        checks += 2;
        if (exp_val.size() != 0) begin errors++; $display("FAIL rand_lost_results got=%0d exp=0", exp_val.size()); end
        if (bsy[0] !== 1'b0)     begin errors++; $display("FAIL rand_busy_after_drain got=%b exp=0", bsy[0]); end
    endtask

    initial begin
        test_reset();
        test_latency_values();
        test_back_to_back_stall();
        test_squash();
        test_async_reset();
        test_random_stream();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mult_execution_unit.md
MULT_EXECUTION_UNIT -- requirements
Module: mult_execution_unit

Interface
REQ-001 Parameter XLEN, default 32, operand/result width.
REQ-002 Parameter STAGES, default 4, pipeline depth; legal 1..8, XLEN % STAGES == 0 SHALL hold.
REQ-003 Parameter TAG_W, default 5, ROB tag width.
REQ-004 clock  input  1  sole clock, rising edge.
REQ-005 reset  input  1  asynchronous, active-high; clears all state immediately.
REQ-006 in_valid  input  1  issue request from RS.
REQ-007 in_ready  output  1  unit accepts issue this cycle.
REQ-008 opa  input  XLEN  rs1 value.
REQ-009 opb  input  XLEN  rs2 value.
REQ-010 func  input  2  00 MUL, 01 MULH, 10 MULHSU, 11 MULHU.
REQ-011 rob_tag  input  TAG_W  destination ROB tag.
REQ-012 squash  input  1  mispredict flush of all in-flight ops.
REQ-013 out_valid  output  1  CDB request; result available.
REQ-014 out_value  output  XLEN  selected result half.
REQ-015 out_rob_tag  output  TAG_W  tag of out_value.
REQ-016 cdb_grant  input  1  CDB accepts current result this cycle.
REQ-017 busy  output  1  any stage valid.

Function
REQ-018 Issue handshake: op accepted at rising edge when in_valid & in_ready.
REQ-019 in_ready SHALL be ~squash & ~(out_valid & ~cdb_grant).
REQ-020 Operands SHALL extend to 2*XLEN at issue: opa signed for MUL/MULH/MULHSU, zero otherwise; opb signed for MUL/MULH, zero for MULHSU/MULHU.
REQ-021 Each stage SHALL hold valid, tag, func, multiplicand, remaining multiplier, 2*XLEN partial sum; each stage adds XLEN/STAGES multiplier bits (shift-add), full 2*XLEN product complete after last stage.
REQ-022 Product arithmetic SHALL be modulo 2^(2*XLEN).
REQ-023 out_value SHALL be product[XLEN-1:0] for MUL, product[2*XLEN-1:XLEN] otherwise; 0 when out_valid low.
REQ-024 Latency: op accepted at edge t SHALL present out_valid after edge t+STAGES absent stalls.
REQ-025 Throughput: one op per cycle; back-to-back issues SHALL produce back-to-back results in issue order.
REQ-026 Stall: out_valid & ~cdb_grant SHALL freeze every stage (global stall); out_value/out_rob_tag stable while stalled.
REQ-027 Result retired on the edge where out_valid & cdb_grant; simultaneous new issue SHALL be accepted that same edge.
REQ-028 Bubbles SHALL propagate as invalid stages; cdb_grant while out_valid low has no effect.
REQ-029 squash SHALL clear all stage valid bits at next edge, overriding stall and grant; issue that cycle SHALL be ignored.
REQ-030 busy SHALL be OR of stage valid bits.

Reset
REQ-031 reset high SHALL asynchronously clear all valid bits; out_valid=0, out_value=0, out_rob_tag=0, busy=0, in_ready=1 (squash low).
REQ-032 reset asserted mid-operation SHALL discard all in-flight ops; no result emitted after release.
REQ-033 First issue SHALL be accepted on first rising edge after reset deasserts.

Verification
REQ-034 XLEN=32, STAGES=4: MUL opa=7 opb=6 tag=3, grant held 1 -> out_valid 4 cycles later, out_value=42, tag=3, one cycle only.
REQ-035 MULH 0x80000000*0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE; MULHSU 0xFFFFFFFF*2 -> 0xFFFFFFFF; MUL 0xFFFFFFFF*0xFFFFFFFF -> 0x00000001.
REQ-036 Issue 5 ops back-to-back, grant low 3 cycles at first result -> in_ready low those 3 cycles, all 5 results in order, values intact, none lost or duplicated.
REQ-037 Issue 3 ops, assert squash with in_valid=1 two cycles later -> busy=0 next cycle, no out_valid ever, in_ready low during squash cycle.
REQ-038 Assert reset asynchronously between edges with 4 ops in flight -> out_valid/busy drop immediately, stay 0 after release until new issue.
REQ-039 Repeat REQ-034/035 with STAGES=1 and STAGES=8 -> latency 1 and 8 respectively, identical values.
